// File: rtl/msg_block_packer.sv
// Packs an 8-bit valid/ready byte stream into KEY_SIZE-bit blocks, zero-padding a short final block.
// Latency: blk_valid rises one cycle after the byte that completes a block; one block per NB+1 cycles at best.
// Backpressure: in_ready drops while a block is held; the block stays stable until blk_valid & blk_ready.
module msg_block_packer #(
    parameter int KEY_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [KEY_SIZE-1:0]           blk_data,
    output logic                          blk_valid,
    output logic                          blk_last,
    output logic [$clog2(KEY_SIZE/8):0]   blk_nbytes,
    input  logic                          blk_ready
);

    localparam int NB = KEY_SIZE / 8;
    localparam int CW = $clog2(NB) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic [KEY_SIZE-1:0]  data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        nb_q, nb_d;

    logic                 byte_xfer;
    logic                 blk_xfer;
    logic                 blk_done;

    // in_ready is decoded from state only (plus reset), so blk_ready never reaches it combinationally.
    assign in_ready  = rst_n & (state_q == ST_FILL);
    assign byte_xfer = in_valid & in_ready;
    assign blk_xfer  = vld_q & blk_ready;
    // A block closes on its last slot or on the message's final byte, whichever comes first.
    assign blk_done  = byte_xfer & (in_last | (idx_q == LAST_IDX));

    assign blk_data   = data_q;
    assign blk_valid  = vld_q;
    assign blk_last   = last_q;
    assign blk_nbytes = nb_q;

    // Next-state: gather bytes into the buffer in FILL, present and release the block in HOLD.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        vld_d   = vld_q;
        last_d  = last_q;
        nb_d    = nb_q;
        case (state_q)
            ST_FILL: begin
                if (byte_xfer) begin
                    // First byte lands in the most significant lane; unwritten lanes stay zero.
                    for (int b = 0; b < NB; b++) begin
                        if (idx_q == CW'(b)) begin
                            data_d[KEY_SIZE-1-8*b -: 8] = in_data;
                        end
                    end
                    // Index never runs past the last lane; a full block always moves to HOLD.
                    idx_d = (idx_q == LAST_IDX) ? idx_q : idx_q + CW'(1);
                    if (blk_done) begin
                        state_d = ST_HOLD;
                        vld_d   = 1'b1;
                        last_d  = in_last;
                        nb_d    = idx_q + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                // The handoff cycle accepts no byte; the buffer is wiped so the next block pads with zeros.
                if (blk_xfer) begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                    data_d  = '0;
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    nb_d    = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and output registers; reset discards any partial or held block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            nb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            nb_q    <= nb_d;
        end
    end

endmodule

// File: tb/tb_msg_block_packer.sv
// Bench for msg_block_packer at KEY_SIZE=32: directed block cases plus a randomized byte stream.
// Outputs are compared every cycle against a queue-based model of the packing rules.
// Drives inputs at posedge+1 and samples on the falling edge.
module tb_msg_block_packer;

    localparam int KEY_SIZE = 32;
    localparam int NB = KEY_SIZE / 8;
    localparam int CW = $clog2(NB) + 1;

    logic                 clk;
    logic                 rst_n;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [KEY_SIZE-1:0]  blk_data;
    logic                 blk_valid;
    logic                 blk_last;
    logic [CW-1:0]        blk_nbytes;
    logic                 blk_ready;

    logic                 rand_rdy;
    logic                 dir_rdy;
    logic                 rnd_rdy;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0]           m_cur[$];
    logic                 m_hold;
    logic [KEY_SIZE-1:0]  m_data;
    int                   m_nb;
    logic                 m_last;

    // observed traffic
    logic [7:0]           tx_bytes[$];
    logic [7:0]           rx_bytes[$];
    logic [KEY_SIZE-1:0]  rxb_data[$];
    int                   rxb_nb[$];
    logic                 rxb_last[$];

    assign blk_ready = rand_rdy ? rnd_rdy : dir_rdy;

    msg_block_packer #(.KEY_SIZE(KEY_SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_last   (blk_last),
        .blk_nbytes (blk_nbytes),
        .blk_ready  (blk_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Random downstream readiness, only used while rand_rdy is set.
    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Per-cycle compare, transfer monitor, then advance the model by the upcoming edge.
    initial begin
        m_hold = 1'b0;
        m_data = '0;
        m_nb   = 0;
        m_last = 1'b0;
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, rst_n && !m_hold);
            chk("blk_valid", blk_valid, m_hold);
            if (m_hold) begin
                chk("blk_data", blk_data, m_data);
                chk("blk_nbytes", blk_nbytes, m_nb);
                chk("blk_last", blk_last, m_last);
            end
            chk("idx_range", dut.idx_q <= CW'(NB - 1), 1);

            if (rst_n && blk_valid && blk_ready) begin
                rxb_data.push_back(blk_data);
                rxb_nb.push_back(int'(blk_nbytes));
                rxb_last.push_back(blk_last);
                for (int k = 0; k < int'(blk_nbytes); k++) begin
                    rx_bytes.push_back(blk_data[KEY_SIZE-1-8*k -: 8]);
                end
            end

            if (!rst_n) begin
                m_cur.delete();
                m_hold = 1'b0;
            end else if (m_hold) begin
                if (blk_ready) m_hold = 1'b0;
            end else if (in_valid) begin
                m_cur.push_back(in_data);
                if (m_cur.size() == NB || in_last) begin
                    m_data = '0;
                    foreach (m_cur[k]) m_data[KEY_SIZE-1-8*k -: 8] = m_cur[k];
                    m_nb   = m_cur.size();
                    m_last = in_last;
                    m_hold = 1'b1;
                    m_cur.delete();
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until the packer takes it (bounded).
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        logic r;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %h not accepted within 200 cycles", d);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rxb_data.delete();
        rxb_nb.delete();
        rxb_last.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rand_rdy = 1'b0;
        dir_rdy  = 1'b1;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_data", blk_data, 0);
        chk("rst_blk_nbytes", blk_nbytes, 0);
        chk("rst_blk_last", blk_last, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: full block, valid the cycle after the 4th byte
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        chk("t1_valid", blk_valid, 1);
        chk("t1_data", blk_data, 32'h11223344);
        chk("t1_nbytes", blk_nbytes, 4);
        chk("t1_last", blk_last, 0);
        cyc();

        // 2: short final block is zero-padded
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b1);
        @(negedge clk);
        chk("t2_valid", blk_valid, 1);
        chk("t2_data", blk_data, 32'hA1B20000);
        chk("t2_nbytes", blk_nbytes, 2);
        chk("t2_last", blk_last, 1);
        cyc();

        // 3: stalled downstream keeps the block stable and input closed
        dir_rdy = 1'b0;
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_hold_valid", blk_valid, 1);
            chk("t3_hold_data", blk_data, 32'hDEADBEEF);
            chk("t3_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        cyc();
        dir_rdy = 1'b1;
        cyc();
        @(negedge clk);
        chk("t3_after_valid", blk_valid, 0);
        chk("t3_after_in_ready", in_ready, 1);
        cyc();

        // 4: six-byte message splits into a full and a padded block
        clear_rx();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
        repeat (3) cyc();
        chk("t4_nblocks", rxb_data.size(), 2);
        if (rxb_data.size() == 2) begin
            chk("t4_b0_data", rxb_data[0], 32'h01020304);
            chk("t4_b0_nbytes", rxb_nb[0], 4);
            chk("t4_b0_last", rxb_last[0], 0);
            chk("t4_b1_data", rxb_data[1], 32'h05060000);
            chk("t4_b1_nbytes", rxb_nb[1], 2);
            chk("t4_b1_last", rxb_last[1], 1);
        end

        // 5: reset mid-block discards the partial bytes
        clear_rx();
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_in_ready", in_ready, 0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rst_data", blk_data, 0);
        chk("t5_rst_valid", blk_valid, 0);
        chk("t5_rst_nbytes", blk_nbytes, 0);
        cyc();
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        repeat (3) cyc();
        chk("t5_nblocks", rxb_data.size(), 1);
        if (rxb_data.size() == 1) begin
            chk("t5_data", rxb_data[0], 32'hC0C1C2C3);
            chk("t5_nbytes", rxb_nb[0], 4);
        end

        // 6: random gaps on both sides over 1000 bytes
        clear_rx();
        tx_bytes.delete();
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] b;
            logic       l;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) cyc();
            end
            b = 8'($urandom);
            l = (n == 999) || ($urandom_range(0, 9) == 0);
            send_byte(b, l);
            tx_bytes.push_back(b);
        end
        rand_rdy = 1'b0;
        dir_rdy  = 1'b1;
        repeat (10) cyc();
        chk("t6_len", rx_bytes.size(), tx_bytes.size());
        if (rx_bytes.size() == tx_bytes.size()) begin
            int bad;
            bad = 0;
            foreach (tx_bytes[i]) if (rx_bytes[i] !== tx_bytes[i]) bad++;
            chk("t6_byte_mismatches", bad, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
